// File: rtl/count_down_yi.sv
// count_down_yi: loadable down-counter with an IDLE/RUN control FSM.
//
// A start request in IDLE latches start_number and runs for exactly that many
// enabled cycles; enable=0 stalls the count, stop aborts without a done pulse.
// cnt_q shows the remaining count minus one while running, and done pulses for
// one cycle after the terminal edge.  A start with start_number=0 produces an
// immediate done pulse without entering RUN.
//
// Build option: define COUNT_DOWN_YI_AUTORELOAD_EN for periodic operation -- the
// terminal edge reloads from the latched start value and the block stays in
// RUN until stop or reset.
module count_down_yi #(
    parameter int BITS_OF_START_NUMBER = 20
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            enable,
    input  logic                            stop,
    input  logic [BITS_OF_START_NUMBER-1:0] start_number,
    output logic [BITS_OF_START_NUMBER-1:0] cnt_q,
    output logic                            busy,
    output logic                            done
);

    localparam int W = BITS_OF_START_NUMBER;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   cnt_d;
    logic [W-1:0]   load_q, load_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    // Terminal condition: an enabled RUN cycle with nothing left to count.
    // The decrement is only ever taken when cnt_q is non-zero, so cnt_q
    // cannot wrap below zero.
    logic           cnt_zero;
    assign cnt_zero = (cnt_q == '0);

`ifndef COUNT_DOWN_YI_AUTORELOAD_EN
    // The latched start value only feeds the reload path in periodic mode;
    // one-shot mode keeps the register but never reads it back.
    logic unused_load;
    assign unused_load = ^load_q;
`endif

    // Next-state and next-output computation for the counter FSM.
    always_comb begin
        // NOTE: every signal gets a hold/idle default first so no path through
        // the case statement can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // stop blocks start; start_number is sampled only here.
                if (start && !stop) begin
                    if (start_number != '0) begin
                        load_d  = start_number;
                        cnt_d   = start_number - ONE;
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end else begin
                        // Zero-length request: finish immediately, stay idle.
                        cnt_d  = '0;
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (stop) begin
                    // Abort wins over enable and the terminal condition.
                    state_d = IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (enable) begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - ONE;
                    end else begin
                        done_d = 1'b1;
`ifdef COUNT_DOWN_YI_AUTORELOAD_EN
                        // load_q is at least 1 whenever RUN was entered.
                        cnt_d = load_q - ONE;
`else
                        state_d = IDLE;
                        cnt_d   = '0;
                        busy_d  = 1'b0;
`endif
                    end
                end
                // enable=0: everything holds via the defaults above.
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset to all-zero.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // computed before this edge, independent of statement order.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            load_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: doc/count_down_yi.md
COUNT_DOWN_YI -- requirements
Module: count_down_yi

Interface
REQ-001 SHALL provide parameter BITS_OF_START_NUMBER, default 20, the width of start_number and cnt_q.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to load start_number and begin counting; sampled only in IDLE.
REQ-005 SHALL have port enable  input  1  count advance in RUN; low = stall, cnt_q held.
REQ-006 SHALL have port stop  input  1  abort; returns to IDLE without done.
REQ-007 SHALL have port start_number  input  BITS_OF_START_NUMBER  number of enabled cycles to count, unsigned.
REQ-008 SHALL have port cnt_q  output  BITS_OF_START_NUMBER  remaining count, registered.
REQ-009 SHALL have port busy  output  1  high while state is RUN, registered.
REQ-010 SHALL have port done  output  1  one-cycle terminal pulse, registered.

Function
REQ-011 SHALL implement states IDLE and RUN, plus an internal load register holding the latched start_number.
REQ-012 In IDLE with start=1 and stop=0 and start_number>=1, the block SHALL latch start_number, load cnt_q <= start_number-1, and enter RUN on that edge.
REQ-013 In IDLE with start=1, stop=0 and start_number=0, the block SHALL stay in IDLE, keep cnt_q=0, and assert done for the next cycle.
REQ-014 In RUN with enable=1, stop=0 and cnt_q>0, the block SHALL decrement cnt_q by exactly 1 per edge.
REQ-015 In RUN with enable=0 and stop=0, the block SHALL hold cnt_q, state and busy unchanged.
REQ-016 The terminal edge is RUN with enable=1, stop=0 and cnt_q=0; on it the block SHALL assert done for exactly the following cycle.
REQ-017 Without auto-reload, the terminal edge SHALL set state to IDLE, busy to 0 and cnt_q to 0.
REQ-018 The block SHALL therefore consume exactly N enabled RUN cycles for start_number=N>=1, independent of stall cycles.
REQ-019 In RUN, stop=1 SHALL take priority over enable and the terminal condition: IDLE, cnt_q=0, busy=0, and no done pulse.
REQ-020 start in RUN SHALL be ignored; start_number changes during RUN SHALL have no effect.
REQ-021 In IDLE, stop=1 SHALL block start on that edge; state remains IDLE.
REQ-022 done SHALL be 0 on every cycle not covered by REQ-013/REQ-016.
REQ-023 cnt_q SHALL never underflow; no arithmetic wrap past 0 is permitted.
REQ-024 A new start SHALL be accepted on the first IDLE cycle after terminal, giving back-to-back runs with one idle cycle.

Reset
REQ-025 reset=1 at a rising edge SHALL force IDLE, cnt_q=0, busy=0, done=0 and the load register to 0.
REQ-026 reset SHALL override start, stop and enable, including mid-RUN; no done pulse results.
REQ-027 reset SHALL take effect only on a clock edge; there is no asynchronous path.

Configuration
REQ-028 Macro COUNT_DOWN_YI_AUTORELOAD_EN SHALL select periodic operation when defined.
REQ-029 With it defined, the terminal edge SHALL pulse done, reload cnt_q <= load register - 1, and remain in RUN with busy=1.
REQ-030 With it defined, only stop or reset SHALL leave RUN.
REQ-031 Without it, REQ-017 SHALL apply.

Verification
REQ-032 Basic count: start_number=5, start pulse, enable held 1. cnt_q SHALL read 4,3,2,1,0; done SHALL be high for 1 cycle after the 0 cycle; busy SHALL be high for 5 cycles.
REQ-033 Stall: start_number=3, enable toggling 1,0,0,1,1. Each enable=0 cycle SHALL hold cnt_q; done SHALL pulse only after the third enabled cycle.
REQ-034 Abort: start_number=10, stop=1 when cnt_q=6. Next cycle SHALL show cnt_q=0 and busy=0; done SHALL stay 0.
REQ-035 Edge inputs: start_number=0 in IDLE -> done SHALL pulse next cycle with busy=0. start+stop together in IDLE -> SHALL be ignored. start_number=1 -> one RUN cycle at cnt_q=0, then done.
REQ-036 Reset mid-run: start_number=8, reset at cnt_q=3 -> SHALL return to all-zero outputs. A subsequent start with start_number=2 -> SHALL count normally.
REQ-037 Auto-reload (macro defined): start_number=3 for 9 enabled cycles. cnt_q SHALL read 2,1,0,2,1,0,2,1,0; done SHALL pulse three times; busy SHALL stay 1 until stop.
